// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: drives the data-memory handshake, builds lane enables
// and replicated store data, and extends load data. Holds the pipeline while an access is outstanding.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [1:0]  store_type,
  input  logic [1:0]  load_type,
  input  logic        load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic        misaligned,
  output logic [31:0] load_data,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [3:0]  dmem_byte_enable,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp
);

  // state    | meaning
  // S_IDLE   | waiting for a memory instruction
  // S_ACCESS | request on the memory bus, waiting for dmem_resp
  // S_DONE   | completion pulse; pipeline advances
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t      state, state_next;
  logic        accept, mis_now, mis_q, store_q, unsigned_q;
  logic [1:0]  type_q, off_q;
  logic [3:0]  be_now;
  logic [31:0] wdata_now, ext_data;
  logic [15:0] half_lane;
  logic [7:0]  byte_lane;

  // Request decode: misalignment, lane enables and replicated write data.
  always_comb begin
    accept    = req_valid & (is_load | is_store);
    mis_now   = 1'b0;
    be_now    = 4'b0000;
    wdata_now = store_data;
    if (is_store) begin
      case (store_type)
        2'd1: begin
          be_now    = 4'b0001 << addr[1:0];
          wdata_now = {4{store_data[7:0]}};
        end
        2'd2: begin
          mis_now   = addr[0];
          be_now    = 4'b0011 << addr[1:0];
          wdata_now = {2{store_data[15:0]}};
        end
        default: begin
          mis_now = |addr[1:0];
          be_now  = 4'b1111;
        end
      endcase
    end else begin
      case (load_type)
        2'd1:    mis_now = 1'b0;
        2'd2:    mis_now = addr[0];
        default: mis_now = |addr[1:0];
      endcase
    end
  end

  // Aligned halfwords only ever sit at offset 0 or 2, so the lane pick equals the shift.
  always_comb begin
    half_lane = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (off_q)
      2'd0:    byte_lane = dmem_rdata[7:0];
      2'd1:    byte_lane = dmem_rdata[15:8];
      2'd2:    byte_lane = dmem_rdata[23:16];
      default: byte_lane = dmem_rdata[31:24];
    endcase
    case (type_q)
      2'd1:    ext_data = unsigned_q ? {24'd0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      2'd2:    ext_data = unsigned_q ? {16'd0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default: ext_data = dmem_rdata;
    endcase
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          stall      = 1'b1;
          state_next = mis_now ? S_DONE : S_ACCESS;
        end
      end
      S_ACCESS: begin
        stall = 1'b1;
        if (dmem_resp) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    misaligned = done & mis_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      store_q          <= 1'b0;
      unsigned_q       <= 1'b0;
      type_q           <= 2'd0;
      off_q            <= 2'd0;
      mis_q            <= 1'b0;
      dmem_read        <= 1'b0;
      dmem_write       <= 1'b0;
      dmem_address     <= 32'd0;
      dmem_byte_enable <= 4'd0;
      dmem_wdata       <= 32'd0;
      load_data        <= 32'd0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (accept) begin
            store_q          <= is_store;
            type_q           <= load_type;
            unsigned_q       <= load_unsigned;
            off_q            <= addr[1:0];
            mis_q            <= mis_now;
            dmem_address     <= {addr[31:2], 2'b00};
            dmem_byte_enable <= be_now;
            dmem_wdata       <= wdata_now;
            dmem_read        <= ~is_store & ~mis_now;
            dmem_write       <= is_store & ~mis_now;
            if (~is_store & mis_now) load_data <= 32'd0;
          end
        end
        S_ACCESS: begin
          if (dmem_resp) begin
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            if (!store_q) load_data <= ext_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
